// File: rtl/frame_pkg.sv
// Shared types and widths for the frame checker slice.
package frame_pkg;

    localparam int BYTE_W = 8;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        LEN,
        PAYLOAD,
        CHECK,
        DISCARD
    } state_e;

endpackage

// File: rtl/frame_timeout.sv
// Mid-frame idle counter; expired fires on the TIMEOUT-th idle cycle.
module frame_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = inc && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || expired) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_checker.sv
// Length-prefixed, checksummed frame parser feeding a speculative FIFO.
// Define FRAME_CHECKER_STATS_EN to build the good/drop frame counters.
module frame_checker
    import frame_pkg::*;
#(
    parameter int MAX_LEN = 15,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              fifo_valid,
    output logic [BYTE_W-1:0] fifo_data,
    input  logic              fifo_ready,
    output logic              fifo_commit,
    output logic              fifo_revert,
    output logic              frame_good,
    output logic              frame_drop,
    output logic [STAT_W-1:0] good_cnt,
    output logic [STAT_W-1:0] drop_cnt
);

    localparam logic [BYTE_W-1:0] MAX_L = BYTE_W'(MAX_LEN);

    state_e            state, state_nx;
    logic [BYTE_W-1:0] sum, sum_nx, sum_add;
    logic [BYTE_W:0]   remaining, rem_nx;
    logic              commit_nx, revert_nx, good_nx, drop_nx;
    logic              accept, idle_inc, idle_clr, expired;

    assign accept   = in_valid && in_ready;
    assign sum_add  = sum + in_data;
    assign idle_inc = (state != LEN) && !in_valid;
    assign idle_clr = (state == LEN) || accept;

    frame_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (idle_clr),
        .inc     (idle_inc),
        .expired (expired)
    );

    always_comb begin
        state_nx   = state;
        sum_nx     = sum;
        rem_nx     = remaining;
        in_ready   = 1'b1;
        fifo_valid = 1'b0;
        fifo_data  = in_data;
        commit_nx  = 1'b0;
        revert_nx  = 1'b0;
        good_nx    = 1'b0;
        drop_nx    = 1'b0;
        unique case (state)
            LEN: begin
                if (accept) begin
                    if (in_data == '0) begin
                        drop_nx = 1'b1;
                    end else if (in_data > MAX_L) begin
                        state_nx = DISCARD;
                        rem_nx   = {1'b0, in_data} + 9'd1;
                    end else begin
                        state_nx = PAYLOAD;
                        rem_nx   = {1'b0, in_data};
                        sum_nx   = in_data;
                    end
                end
            end
            PAYLOAD: begin
                in_ready   = fifo_ready;
                fifo_valid = in_valid && fifo_ready;
                if (accept) begin
                    sum_nx = sum_add;
                    rem_nx = remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        state_nx = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_nx = LEN;
                    sum_nx   = '0;
                    rem_nx   = '0;
                    if (sum_add == '0) begin
                        commit_nx = 1'b1;
                        good_nx   = 1'b1;
                    end else begin
                        revert_nx = 1'b1;
                        drop_nx   = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (accept) begin
                    rem_nx = remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        state_nx = LEN;
                        drop_nx  = 1'b1;
                    end
                end
            end
        endcase
        // Oversize frames never wrote anything, so they have nothing to revert.
        if (expired) begin
            state_nx  = LEN;
            sum_nx    = '0;
            rem_nx    = '0;
            drop_nx   = 1'b1;
            revert_nx = (state != DISCARD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LEN;
            sum         <= '0;
            remaining   <= '0;
            fifo_commit <= 1'b0;
            fifo_revert <= 1'b0;
            frame_good  <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            state       <= state_nx;
            sum         <= sum_nx;
            remaining   <= rem_nx;
            fifo_commit <= commit_nx;
            fifo_revert <= revert_nx;
            frame_good  <= good_nx;
            frame_drop  <= drop_nx;
        end
    end

`ifdef FRAME_CHECKER_STATS_EN
    logic [STAT_W-1:0] good_q, drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            good_q <= '0;
            drop_q <= '0;
        end else begin
            if (frame_good && (good_q != '1)) begin
                good_q <= good_q + 1'b1;
            end
            if (frame_drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign good_cnt = good_q;
    assign drop_cnt = drop_q;
`else
    assign good_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_checker.sv
// Self-checking bench for frame_checker: frame table plus hand-written corner cases.
module tb_frame_checker;

    localparam logic [3:0] E_GOOD = 4'b1010;
    localparam logic [3:0] E_BAD  = 4'b0101;
    localparam logic [3:0] E_DROP = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        fifo_valid;
    logic [7:0]  fifo_data;
    logic        fifo_ready;
    logic        fifo_commit;
    logic        fifo_revert;
    logic        frame_good;
    logic        frame_drop;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    frame_checker #(
        .MAX_LEN (15),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .fifo_ready  (fifo_ready),
        .fifo_commit (fifo_commit),
        .fifo_revert (fifo_revert),
        .frame_good  (frame_good),
        .frame_drop  (frame_drop),
        .good_cnt    (good_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        int         n;
        logic [7:0] b [24];
        logic [3:0] endc;
        bit         wr;
    } frame_t;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } ev_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_good = 0;
    int         n_drop = 0;
    int         nrec = 0;
    frame_t     tbl [12];
    logic [7:0] wq [$];
    ev_t        eq [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [3:0] p;
        ev_t        e;
        p = {fifo_commit, fifo_revert, frame_good, frame_drop};
        chk("pulse_write_overlap", 32'(fifo_valid && (p != 4'd0)), 0);
        if (fifo_valid) begin
            total++;
            if (wq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got=%0h want=none", fifo_data);
            end else begin
                total--;
                chk("write_data", fifo_data, wq.pop_front());
            end
        end
        if (p != 4'd0) begin
            total++;
            if (eq.size() == 0) begin
                bad++;
                $display("FAIL spurious_pulse got=%0h want=0 cyc=%0d", p, cyc);
            end else begin
                total--;
                e = eq.pop_front();
                chk("pulse_code", p, e.code);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end else if (eq.size() != 0 && eq[0].cyc <= cyc) begin
            e = eq.pop_front();
            chk("missed_pulse", 0, e.code);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic fr,
                        input logic exp_rdy, input logic wr, input logic [3:0] endc);
        ev_t e;
        in_valid   = v;
        in_data    = d;
        fifo_ready = fr;
        if (wr) wq.push_back(d);
        @(negedge clk);
        monitor();
        chk("in_ready", in_ready, exp_rdy);
        if (endc != 4'd0) begin
            e.cyc  = cyc + 1;
            e.code = endc;
            eq.push_back(e);
            if (endc[1]) n_good++;
            if (endc[0]) n_drop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic put(input logic [7:0] v);
        tbl[nrec].b[tbl[nrec].n] = v;
        tbl[nrec].n++;
    endtask

    task automatic close(input logic [3:0] endc, input bit wr);
        tbl[nrec].endc = endc;
        tbl[nrec].wr   = wr;
        nrec++;
        tbl[nrec].n = 0;
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < f.n; i++) begin
            tick(1'b1, f.b[i], 1'b1, 1'b1,
                 f.wr && (i > 0) && (i < f.n - 1),
                 (i == f.n - 1) ? f.endc : 4'd0);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef FRAME_CHECKER_STATS_EN
        chk({tag, "_good_cnt"}, good_cnt, n_good);
        chk({tag, "_drop_cnt"}, drop_cnt, n_drop);
`else
        chk({tag, "_good_cnt"}, good_cnt, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        fifo_ready = 1'b1;

        tbl[0].n = 0;
        put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h97); close(E_GOOD, 1);
        put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h00); close(E_BAD, 1);
        put(8'h00); close(E_DROP, 0);
        put(8'h14);
        for (int i = 0; i < 21; i++) put(8'(i * 7 + 1));
        close(E_DROP, 0);
        put(8'h01); put(8'h05); put(8'hFA); close(E_GOOD, 1);
        put(8'h0F);
        for (int i = 1; i <= 15; i++) put(8'(i));
        put(8'h79); close(E_GOOD, 1);
        put(8'h10);
        for (int i = 0; i < 17; i++) put(8'hA5);
        close(E_DROP, 0);
        put(8'h02); put(8'hFF); put(8'hFF); put(8'h00); close(E_GOOD, 1);
        put(8'h02); put(8'hFF); put(8'hFF); put(8'h01); close(E_BAD, 1);
        put(8'h01); put(8'h00); put(8'hFF); close(E_GOOD, 1);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fifo_valid", fifo_valid, 0);
        chk("rst_pulses", {fifo_commit, fifo_revert, frame_good, frame_drop}, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;

        for (int r = 0; r < nrec; r++) send_frame(tbl[r]);
        idle(2);

        // Payload timeout: 8th idle cycle aborts, then a frame commits.
        tick(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 4'd0);
        tick(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 4'd0);
        idle(7);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, E_BAD);
        send_frame(tbl[4]);
        idle(1);

        // Timeout while waiting for the check byte.
        tick(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 4'd0);
        idle(7);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, E_BAD);
        idle(1);

        // Timeout inside an oversize frame: drop only, no revert.
        tick(1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(7);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, E_DROP);
        idle(1);

        // Backpressure longer than TIMEOUT must not abort the frame.
        tick(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 4'd0);
        tick(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 4'd0);
        tick(1'b1, 8'h97, 1'b1, 1'b1, 1'b0, E_GOOD);
        idle(3);
        chk_stats("pre_reset");

        // Reset mid-frame: no pulse, counters clear, next frame commits.
        tick(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 4'd0);
        tick(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 4'd0);
        reset = 1'b1;
        idle(1);
        reset  = 1'b0;
        n_good = 0;
        n_drop = 0;
        idle(2);
        chk_stats("post_reset");
        send_frame(tbl[0]);
        idle(3);
        chk_stats("final");

        chk("write_queue_empty", wq.size(), 0);
        chk("event_queue_empty", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
